wb_port_scheduler: RTL and testbench

Write-back port scheduler for the 16-bit pipeline. It sits between the MEM/WB pipeline register and the single-write-port register file. Single-destination instructions commit in one cycle. Dual-destination instructions (product/quotient high half to R15) are sequenced over two cycles while the upstream pipeline is held. It also drives the write-back forwarding bus used by the execute-stage bypass.

---
 rtl/wb_port_scheduler_pkg.sv | 19 +
 rtl/wb_port_scheduler_if.sv | 34 +++
 rtl/wb_port_scheduler.sv | 93 +++++++++
 tb/tb_wb_port_scheduler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/wb_port_scheduler_pkg.sv
// Shared write-back pipeline definitions: datapath sizes, MEM/WB regwrite bit
// positions and the write-back scheduler state encoding.
package wb_port_scheduler_pkg;

    localparam int PKG_DW = 16;
    localparam int PKG_AW = 4;

    localparam logic [3:0] HI_REG_DEF = 4'd15;

    localparam int RW_PRI    = 0;
    localparam int RW_MEMSEL = 1;
    localparam int RW_HI     = 2;

    typedef enum logic {
        PRI = 1'b0,
        SEC = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_port_scheduler_if.sv
// Bundle between MEM/WB, the write-back scheduler, the register-file write port
// and the execute-stage bypass.
interface wb_port_scheduler_if #(
    parameter int DW = 16,
    parameter int AW = 4
);
    logic [2:0]    in_regwrite;
    logic [AW-1:0] in_dst;
    logic [DW-1:0] in_alu;
    logic [DW-1:0] in_mem;
    logic [DW-1:0] in_hi;
    logic          flush;

    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          stall;
    logic          fwd_valid;
    logic [AW-1:0] fwd_addr;
    logic [DW-1:0] fwd_data;
    logic          busy;

    modport master (
        output in_regwrite, in_dst, in_alu, in_mem, in_hi, flush,
        input  rf_we, rf_waddr, rf_wdata, stall,
        input  fwd_valid, fwd_addr, fwd_data, busy
    );

    modport slave (
        input  in_regwrite, in_dst, in_alu, in_mem, in_hi, flush,
        output rf_we, rf_waddr, rf_wdata, stall,
        output fwd_valid, fwd_addr, fwd_data, busy
    );
endinterface

// File: rtl/wb_port_scheduler.sv
// Write-back port scheduler: commits single writes in one cycle and splits
// dual-destination results over two cycles while holding the pipeline.
module wb_port_scheduler
    import wb_port_scheduler_pkg::*;
#(
    parameter int            DW     = PKG_DW,
    parameter int            AW     = PKG_AW,
    parameter logic [AW-1:0] HI_REG = AW'(HI_REG_DEF)
) (
    input  logic               clk,
    input  logic               reset,
    wb_port_scheduler_if.slave bus
);

    wb_state_e     state_q, state_d;
    logic [DW-1:0] hi_q, hi_d;
    logic [15:0]   dual_cnt_q, dual_cnt_d;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          stall_c;
    logic          go_sec;

    logic rw_pri, rw_mem, rw_hi;

    assign rw_pri = bus.in_regwrite[RW_PRI];
    assign rw_mem = bus.in_regwrite[RW_MEMSEL];
    assign rw_hi  = bus.in_regwrite[RW_HI];

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        stall_c = 1'b0;
        go_sec  = 1'b0;

        if (state_q == SEC) begin
            // A flush here only drops the deferred high write; the primary already committed.
            if (!bus.flush) begin
                wr_en   = 1'b1;
                wr_addr = HI_REG;
                wr_data = hi_q;
            end
        end else if (rw_hi && (!rw_pri || bus.in_dst == HI_REG)) begin
            // Primary aimed at HI_REG is superseded by the high result.
            wr_en   = 1'b1;
            wr_addr = HI_REG;
            wr_data = bus.in_hi;
        end else if (rw_pri) begin
            wr_en   = 1'b1;
            wr_addr = bus.in_dst;
            wr_data = rw_mem ? bus.in_mem : bus.in_alu;
            if (rw_hi) begin
                stall_c = 1'b1;
                go_sec  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = go_sec ? SEC : PRI;
        hi_d       = go_sec ? bus.in_hi : hi_q;
        dual_cnt_d = dual_cnt_q;
        if (go_sec && dual_cnt_q != 16'hFFFF) begin
            dual_cnt_d = dual_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= PRI;
            hi_q       <= '0;
            dual_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            dual_cnt_q <= dual_cnt_d;
        end
    end

    // Outputs are combinational from MEM/WB, so gate them while reset is held.
    assign bus.rf_we     = reset & wr_en;
    assign bus.rf_waddr  = reset ? wr_addr : '0;
    assign bus.rf_wdata  = reset ? wr_data : '0;
    assign bus.stall     = reset & stall_c;
    assign bus.busy      = reset & (state_q == SEC);

    assign bus.fwd_valid = bus.rf_we;
    assign bus.fwd_addr  = bus.rf_waddr;
    assign bus.fwd_data  = bus.rf_wdata;

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed and randomized checks of the write-back scheduler against a
// pending-high-write reference model.
module tb_wb_port_scheduler;
    import wb_port_scheduler_pkg::*;

    localparam logic [3:0] HI = 4'd15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_port_scheduler_if bus ();

    wb_port_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a deferred high write is either outstanding or not.
    bit          m_pend = 1'b0;
    logic [15:0] m_hi   = '0;
    int          m_cnt  = 0;

    logic        e_we;
    logic [3:0]  e_addr;
    logic [15:0] e_data;
    logic        e_stall;
    logic        e_busy;
    bit          e_dual;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void predict();
        logic [2:0] rw;
        rw      = bus.in_regwrite;
        e_we    = 1'b0;
        e_addr  = '0;
        e_data  = '0;
        e_stall = 1'b0;
        e_busy  = m_pend;
        e_dual  = 1'b0;
        if (m_pend) begin
            if (!bus.flush) begin
                e_we = 1'b1; e_addr = HI; e_data = m_hi;
            end
        end else if (rw[2] && rw[0] && bus.in_dst != HI) begin
            e_we = 1'b1; e_addr = bus.in_dst;
            e_data = rw[1] ? bus.in_mem : bus.in_alu;
            e_stall = 1'b1; e_dual = 1'b1;
        end else if (rw[2]) begin
            e_we = 1'b1; e_addr = HI; e_data = bus.in_hi;
        end else if (rw[0]) begin
            e_we = 1'b1; e_addr = bus.in_dst;
            e_data = rw[1] ? bus.in_mem : bus.in_alu;
        end
    endfunction

    task automatic drive(input logic [2:0] rw, input logic [3:0] dst, input logic [15:0] alu,
                         input logic [15:0] mem, input logic [15:0] hi, input logic fl);
        bus.in_regwrite = rw;
        bus.in_dst      = dst;
        bus.in_alu      = alu;
        bus.in_mem      = mem;
        bus.in_hi       = hi;
        bus.flush       = fl;
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        predict();
        chk({tag, ".we"}, 32'(bus.rf_we), 32'(e_we));
        chk({tag, ".fwd_valid"}, 32'(bus.fwd_valid), 32'(e_we));
        if (e_we) begin
            chk({tag, ".waddr"}, 32'(bus.rf_waddr), 32'(e_addr));
            chk({tag, ".wdata"}, 32'(bus.rf_wdata), 32'(e_data));
            chk({tag, ".fwd_addr"}, 32'(bus.fwd_addr), 32'(e_addr));
            chk({tag, ".fwd_data"}, 32'(bus.fwd_data), 32'(e_data));
        end
        chk({tag, ".stall"}, 32'(bus.stall), 32'(e_stall));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(e_busy));
        @(posedge clk);
        #1;
        if (m_pend) begin
            m_pend = 1'b0;
        end else if (e_dual) begin
            m_pend = 1'b1;
            m_hi   = bus.in_hi;
            if (m_cnt < 65535) m_cnt++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".we"}, 32'(bus.rf_we), 0);
        chk({tag, ".waddr"}, 32'(bus.rf_waddr), 0);
        chk({tag, ".wdata"}, 32'(bus.rf_wdata), 0);
        chk({tag, ".stall"}, 32'(bus.stall), 0);
        chk({tag, ".busy"}, 32'(bus.busy), 0);
        chk({tag, ".fwd_valid"}, 32'(bus.fwd_valid), 0);
        chk({tag, ".fwd_addr"}, 32'(bus.fwd_addr), 0);
        chk({tag, ".fwd_data"}, 32'(bus.fwd_data), 0);
        chk({tag, ".hi_q"}, 32'(dut.hi_q), 0);
        chk({tag, ".dual_cnt"}, 32'(dut.dual_cnt_q), 0);
    endtask

    initial begin
        reset = 1'b0;
        drive(3'b101, 4'd2, 16'h1111, 16'h2222, 16'h3333, 1'b0);
        #1;
        chk_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        drive(3'b001, 4'd3, 16'h1234, 16'hDEAD, 16'hBEEF, 1'b0);
        cycle("single_alu");
        drive(3'b011, 4'd7, 16'h1234, 16'hC0DE, 16'hBEEF, 1'b0);
        cycle("single_mem");
        drive(3'b000, 4'd9, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
        cycle("bubble");
        drive(3'b010, 4'd9, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
        cycle("memsel_only");
        drive(3'b100, 4'd1, 16'h0, 16'h0, 16'h4242, 1'b0);
        cycle("hi_only");

        drive(3'b101, 4'd2, 16'h00FF, 16'h0000, 16'hABCD, 1'b0);
        cycle("dual_c1");
        cycle("dual_c2");
        drive(3'b000, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0);
        cycle("dual_c3");

        drive(3'b111, 4'd15, 16'h0000, 16'h5555, 16'h7777, 1'b0);
        cycle("collapse");
        drive(3'b000, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0);
        cycle("collapse_after");

        drive(3'b101, 4'd2, 16'h0A0A, 16'h0000, 16'h9999, 1'b0);
        cycle("flush_c1");
        bus.flush = 1'b1;
        cycle("flush_c2");
        drive(3'b000, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0);
        cycle("flush_c3");

        drive(3'b101, 4'd5, 16'h1357, 16'h0000, 16'h2468, 1'b0);
        cycle("rst_sec_c1");
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("rst_in_sec");
        @(posedge clk);
        #1;
        reset  = 1'b1;
        m_pend = 1'b0;
        m_hi   = '0;
        m_cnt  = 0;
        drive(3'b001, 4'd4, 16'h0001, 16'h0000, 16'h0000, 1'b0);
        cycle("after_rst");

        for (int i = 0; i < 3; i++) begin
            drive(3'b101, 4'(i + 1), 16'(16'h1000 + i), 16'h0, 16'(16'hA000 + i), 1'b0);
            cycle("triple_pri");
            cycle("triple_sec");
        end
        drive(3'b000, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0);
        cycle("triple_end");
        chk("dual_cnt3", 32'(dut.dual_cnt_q), 3);

        for (int i = 0; i < 400; i++) begin
            drive(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 16'($urandom),
                  16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0));
            cycle("rnd");
        end
        chk("dual_cnt_rnd", 32'(dut.dual_cnt_q), 32'(m_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
